// File: rtl/heap_pkg.sv
// Shared types and key helpers for the min-heap top-K selector.
// The key compare matches the one used by sort_node.
package heap_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefKeyWidth  = 16;
    localparam int unsigned MaxDataWidth = 256;

    typedef enum logic [2:0] {
        StInitWait,
        StReady,
        StIssue,
        StSettle1,
        StSettle2
    } heap_state_e;

    // Zero everything above the key so compares are plain unsigned.
    function automatic logic [MaxDataWidth-1:0] key_of(input logic [MaxDataWidth-1:0] d,
                                                       input int unsigned key_width);
        logic [MaxDataWidth-1:0] mask;
        if (key_width >= MaxDataWidth) begin
            mask = '1;
        end else begin
            mask = (MaxDataWidth'(1) << key_width) - MaxDataWidth'(1);
        end
        return d & mask;
    endfunction

    function automatic logic key_gt(input logic [MaxDataWidth-1:0] a,
                                    input logic [MaxDataWidth-1:0] b);
        return a > b;
    endfunction

endpackage

// File: rtl/heap_root_ctrl.sv
// Root (level 0) controller of the pipelined min-heap top-K selector.
// Define HEAP_STAT_EN to add the stat_accept / stat_drop counters.
module heap_root_ctrl
    import heap_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = DefDataWidth,
    parameter int unsigned           KEY_WIDTH  = DefKeyWidth,
    parameter int unsigned           ADDR_WIDTH = 5,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_DATA  = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  init_req,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] heap_min,
    output logic                  node_init,
    output logic                  node_update,
    output logic [ADDR_WIDTH-1:0] node_addr,
    output logic                  node_branch,
    output logic [DATA_WIDTH-1:0] node_data,
    input  logic                  node_um_we,
    input  logic [DATA_WIDTH-1:0] node_um_data
`ifdef HEAP_STAT_EN
    ,
    output logic [31:0]           stat_accept,
    output logic [31:0]           stat_drop
`endif
);

    localparam int unsigned        CntWidth = DEPTH + 2;
    // Init wait covers the time for the init strobe to reach every level.
    localparam logic [CntWidth-1:0] InitLast = CntWidth'((1 << DEPTH) + 1);

    heap_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] root_q, root_d;
    logic [DATA_WIDTH-1:0] node_data_q, node_data_d;
    logic                  node_init_q, node_init_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  in_gt;

    assign in_gt = key_gt(key_of(MaxDataWidth'(in_data), KEY_WIDTH),
                          key_of(MaxDataWidth'(root_q), KEY_WIDTH));

    always_comb begin
        state_d     = state_q;
        root_d      = root_q;
        node_data_d = node_data_q;
        node_init_d = 1'b0;
        cnt_d       = cnt_q;
        in_ready    = 1'b0;

        // A late promotion from level 1 still lands in the root.
        if (node_um_we) begin
            root_d = node_um_data;
        end

        unique case (state_q)
            StInitWait: begin
                root_d = INIT_DATA;
                if (cnt_q == InitLast) begin
                    cnt_d   = '0;
                    state_d = StReady;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StReady: begin
                if (init_req) begin
                    state_d     = StInitWait;
                    root_d      = INIT_DATA;
                    node_init_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid && in_gt) begin
                        root_d      = in_data;
                        node_data_d = in_data;
                        state_d     = StIssue;
                    end
                end
            end
            StIssue:   state_d = StSettle1;
            StSettle1: state_d = StSettle2;
            StSettle2: state_d = StReady;
            default:   state_d = StInitWait;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StInitWait;
            root_q      <= INIT_DATA;
            node_data_q <= '0;
            node_init_q <= 1'b1;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            root_q      <= root_d;
            node_data_q <= node_data_d;
            node_init_q <= node_init_d;
            cnt_q       <= cnt_d;
        end
    end

    assign busy        = (state_q != StReady);
    assign heap_min    = root_q;
    assign node_init   = node_init_q;
    assign node_update = (state_q == StIssue);
    assign node_addr   = '0;
    assign node_branch = 1'b0;
    assign node_data   = node_data_q;

`ifdef HEAP_STAT_EN
    logic [31:0] stat_accept_q, stat_accept_d;
    logic [31:0] stat_drop_q, stat_drop_d;
    logic        take, drop, enter_init;

    always_comb begin
        enter_init    = (state_q == StReady) && init_req;
        take          = (state_q == StReady) && !init_req && in_valid && in_gt;
        drop          = (state_q == StReady) && !init_req && in_valid && !in_gt;
        stat_accept_d = stat_accept_q;
        stat_drop_d   = stat_drop_q;
        if (enter_init) begin
            stat_accept_d = '0;
            stat_drop_d   = '0;
        end else begin
            if (take) stat_accept_d = stat_accept_q + 32'd1;
            if (drop) stat_drop_d   = stat_drop_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_accept_q <= '0;
            stat_drop_q   <= '0;
        end else begin
            stat_accept_q <= stat_accept_d;
            stat_drop_q   <= stat_drop_d;
        end
    end

    assign stat_accept = stat_accept_q;
    assign stat_drop   = stat_drop_q;
`endif

endmodule

// File: tb/tb_heap_root_ctrl.sv
// Directed bench for heap_root_ctrl (DEPTH=2) with a small behavioural level-1..2 heap.
module tb_heap_root_ctrl;

    logic        clk;
    logic        rstn;
    logic        init_req;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        busy;
    logic [31:0] heap_min;
    logic        node_init;
    logic        node_update;
    logic [4:0]  node_addr;
    logic        node_branch;
    logic [31:0] node_data;
    logic        node_um_we;
    logic [31:0] node_um_data;
`ifdef HEAP_STAT_EN
    logic [31:0] stat_accept;
    logic [31:0] stat_drop;
`endif

    int checks;
    int failures;

    heap_root_ctrl #(
        .DATA_WIDTH (32),
        .KEY_WIDTH  (16),
        .ADDR_WIDTH (5),
        .DEPTH      (2),
        .INIT_DATA  (32'd0)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .init_req     (init_req),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .busy         (busy),
        .heap_min     (heap_min),
        .node_init    (node_init),
        .node_update  (node_update),
        .node_addr    (node_addr),
        .node_branch  (node_branch),
        .node_data    (node_data),
        .node_um_we   (node_um_we),
        .node_um_data (node_um_data)
`ifdef HEAP_STAT_EN
        ,
        .stat_accept  (stat_accept),
        .stat_drop    (stat_drop)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Array heap of 7 slots; slot 0 mirrors the root, 1..6 are the node levels.
    logic [31:0] h [7];
    logic        promo;
    int          upd_tag;
    int          seen_tag;

    initial begin
        promo   = 1'b0;
        upd_tag = 0;
    end

    always @(negedge clk) begin : model_sift
        logic [31:0] item;
        int          i;
        int          m;
        bit          done;
        if (node_init) begin
            for (int k = 0; k < 7; k++) h[k] = 32'd0;
        end else if (node_update) begin
            item = node_data;
            i    = 0;
            done = 1'b0;
            while (!done) begin
                if (2 * i + 1 >= 7) begin
                    done = 1'b1;
                end else begin
                    m = 2 * i + 1;
                    if (h[m+1][15:0] < h[m][15:0]) m = m + 1;
                    if (h[m][15:0] < item[15:0]) begin
                        h[i] = h[m];
                        i    = m;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            h[i]    = item;
            promo   = (i != 0);
            upd_tag = upd_tag + 1;
        end
    end

    // Level 1 answers with um_we during the cycle after its update.
    initial begin
        node_um_we   = 1'b0;
        node_um_data = 32'd0;
        seen_tag     = 0;
        forever begin
            @(posedge clk);
            #2;
            if (upd_tag != seen_tag) begin
                seen_tag     = upd_tag;
                node_um_we   = promo;
                node_um_data = h[0];
            end else begin
                node_um_we = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output int n, output int n_init);
        n      = 0;
        n_init = 0;
        do begin
            @(negedge clk);
            n++;
            n_init += int'(node_init);
        end while (!in_ready && n < 20);
    endtask

    task automatic send(input logic [31:0] d, output int n_upd, output int n_cyc);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        n_upd    = 0;
        n_cyc    = 1;
        while (!in_ready && n_cyc < 20) begin
            n_upd += int'(node_update);
            @(negedge clk);
            n_cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n_init;
        int n_upd;
        int n_cyc;
        int tot;
        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        init_req = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;

        // 1. Reset and init wait.
        #12 rstn = 1'b1;
        #1;
        chk("rst_node_init", 32'(node_init), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_heap_min", heap_min, 32'd0);
        chk("rst_node_update", 32'(node_update), 32'd0);
        chk("rst_node_data", node_data, 32'd0);
        chk("rst_node_addr", 32'(node_addr), 32'd0);
        chk("rst_node_branch", 32'(node_branch), 32'd0);
        wait_ready(n, n_init);
        chk("rst_ready_cycles", 32'(n), 32'd6);
        chk("rst_init_pulse_len", 32'(n_init), 32'd0);
        chk("rst_ready_busy", 32'(busy), 32'd0);

        // 2. Accept 5 step by step, then 3 and 9.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'd5;
        #1 chk("p5_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("p5_issue_update", 32'(node_update), 32'd1);
        chk("p5_issue_data", node_data, 32'd5);
        chk("p5_issue_root", heap_min, 32'd5);
        chk("p5_issue_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("p5_s1_update", 32'(node_update), 32'd0);
        chk("p5_s1_um_we", 32'(node_um_we), 32'd1);
        chk("p5_s1_root", heap_min, 32'd5);
        @(negedge clk);
        chk("p5_s2_root", heap_min, 32'd0);
        chk("p5_s2_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("p5_ready", 32'(in_ready), 32'd1);
        send(32'd3, n_upd, n_cyc);
        chk("p3_updates", 32'(n_upd), 32'd1);
        chk("p3_cycles", 32'(n_cyc), 32'd4);
        send(32'd9, n_upd, n_cyc);
        chk("p9_updates", 32'(n_upd), 32'd1);
        chk("p9_root", heap_min, 32'd0);

        // 5a. init_req beats in_valid.
        @(negedge clk);
        init_req = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'd99;
        #1 chk("init_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        init_req = 1'b0;
        in_valid = 1'b0;
        chk("init_node_init", 32'(node_init), 32'd1);
        chk("init_busy", 32'(busy), 32'd1);
        chk("init_no_update", 32'(node_update), 32'd0);
        chk("init_root", heap_min, 32'd0);
        wait_ready(n, n_init);
        chk("init_ready_cycles", 32'(n), 32'd6);
        chk("init_pulse_len", 32'(n_init), 32'd0);
`ifdef HEAP_STAT_EN
        chk("init_stat_accept", stat_accept, 32'd0);
        chk("init_stat_drop", stat_drop, 32'd0);
`endif

        // 3. Fill with 10..70, drop 5, accept 80.
        tot = 0;
        for (int k = 1; k <= 7; k++) begin
            send(32'(k * 10), n_upd, n_cyc);
            tot += n_upd;
            if (k == 6) chk("fill60_root", heap_min, 32'd0);
        end
        chk("fill_updates", 32'(tot), 32'd7);
        chk("fill_root", heap_min, 32'd10);
        send(32'd5, n_upd, n_cyc);
        chk("drop5_updates", 32'(n_upd), 32'd0);
        chk("drop5_cycles", 32'(n_cyc), 32'd1);
        chk("drop5_root", heap_min, 32'd10);
        send(32'd80, n_upd, n_cyc);
        chk("p80_updates", 32'(n_upd), 32'd1);
        chk("p80_cycles", 32'(n_cyc), 32'd4);
        chk("p80_root", heap_min, 32'd20);

        // 4. Back-to-back drops of 1,2,3; the upper bits must not affect the compare.
        in_valid = 1'b1;
        in_data  = 32'hFFFF_0001;
        #1 chk("bb1_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_data = 32'd2;
        #1 chk("bb2_ready", 32'(in_ready), 32'd1);
        chk("bb2_update", 32'(node_update), 32'd0);
        @(negedge clk);
        in_data = 32'd3;
        #1 chk("bb3_ready", 32'(in_ready), 32'd1);
        chk("bb3_update", 32'(node_update), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("bb_end_update", 32'(node_update), 32'd0);
        chk("bb_end_busy", 32'(busy), 32'd0);
        chk("bb_end_root", heap_min, 32'd20);
`ifdef HEAP_STAT_EN
        chk("bb_stat_accept", stat_accept, 32'd8);
        chk("bb_stat_drop", stat_drop, 32'd4);
`endif

        // Equal key is dropped.
        send(32'd20, n_upd, n_cyc);
        chk("eq_updates", 32'(n_upd), 32'd0);
        chk("eq_root", heap_min, 32'd20);

        // 5b. init_req during SETTLE1 is ignored.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'd90;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        chk("s1init_node_init", 32'(node_init), 32'd0);
        chk("s1init_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("s1init_ready", 32'(in_ready), 32'd1);
        chk("s1init_node_init2", 32'(node_init), 32'd0);
        chk("s1init_root", heap_min, 32'd30);

        // 6. Async reset during SETTLE1.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'd100;
        @(negedge clk);
        in_valid = 1'b0;
        chk("r6_issue_update", 32'(node_update), 32'd1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("r6_node_init", 32'(node_init), 32'd1);
        chk("r6_in_ready", 32'(in_ready), 32'd0);
        chk("r6_busy", 32'(busy), 32'd1);
        chk("r6_heap_min", heap_min, 32'd0);
        chk("r6_node_update", 32'(node_update), 32'd0);
        chk("r6_node_data", node_data, 32'd0);
`ifdef HEAP_STAT_EN
        chk("r6_stat_accept", stat_accept, 32'd0);
        chk("r6_stat_drop", stat_drop, 32'd0);
`endif
        @(negedge clk);
        rstn = 1'b1;
        wait_ready(n, n_init);
        chk("r6_ready_cycles", 32'(n), 32'd6);
        chk("r6_root", heap_min, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
